// File: rtl/_shift_reg_en.sv
// Universal WIDTH-bit shift register with enable.
// Modes: hold, parallel load, shift left/right with serial input,
// rotate left/right, clear to RESET_VAL and arithmetic shift right.
// Serial outputs expose the MSB and LSB so registers can be chained.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high; loads RESET_VAL
//   en      enable; 0 holds q whatever the mode
//   mode    operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/CLR/ASR)
//   d       parallel load data
//   si_l    serial input entering at the LSB on SHL
//   si_r    serial input entering at the MSB on SHR
//   q       register contents
//   so_msb  q[WIDTH-1], taken directly from q
//   so_lsb  q[0], taken directly from q
module _shift_reg_en #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_l,
    input  logic             si_r,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_ASR  = 3'b111
    } mode_e;

    // Register update: reset wins, then enable, then mode decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: q <= q;
                MODE_LOAD: q <= d;
                MODE_SHL:  q <= {q[WIDTH-2:0], si_l};
                MODE_SHR:  q <= {si_r, q[WIDTH-1:1]};
                MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
                MODE_CLR:  q <= RESET_VAL;
                // Sign bit replicated; si_r deliberately unused here.
                MODE_ASR:  q <= {q[WIDTH-1], q[WIDTH-1:1]};
                default:   q <= q;
            endcase
        end
    end

    // Serial outputs are plain taps of the register for chaining.
    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];

endmodule

// File: tb/tb__shift_reg_en.sv
// Self-checking bench for _shift_reg_en: two instances (RESET_VAL 00 and A5)
// share stimulus; a behavioural model is compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb__shift_reg_en;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL  = 3'd4, ROR  = 3'd5, CLR = 3'd6, ASR = 3'd7;

    logic       clk = 1'b0;
    logic       rst, en, si_l, si_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q0, q1;
    logic       msb0, lsb0, msb1, lsb1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    _shift_reg_en #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .si_l(si_l), .si_r(si_r), .q(q0), .so_msb(msb0), .so_lsb(lsb0));

    _shift_reg_en #(.WIDTH(8), .RESET_VAL(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .si_l(si_l), .si_r(si_r), .q(q1), .so_msb(msb1), .so_lsb(lsb1));

    // Reference: value arithmetic on the register contents.
    function automatic logic [7:0] model_next(input logic [7:0] cur,
                                              input logic r, input logic e,
                                              input logic [2:0] m,
                                              input logic [7:0] din,
                                              input logic sl, input logic sr,
                                              input logic [7:0] rv);
        logic [7:0] sl8, sr8;
        sl8 = {7'd0, sl};
        sr8 = {7'd0, sr};
        if (r) return rv;
        if (!e) return cur;
        case (m)
            LOAD:    return din;
            SHL:     return 8'((cur << 1) | sl8);
            SHR:     return 8'((sr8 << 7) | (cur >> 1));
            ROL:     return 8'((cur << 1) | (cur >> 7));
            ROR:     return 8'((cur << 7) | (cur >> 1));
            CLR:     return rv;
            ASR:     return 8'((cur & 8'h80) | (cur >> 1));
            default: return cur;
        endcase
    endfunction

    logic [7:0] m0, m1;
    logic       valid = 1'b0;

    always @(posedge clk) begin
        m0 <= model_next(m0, rst, en, mode, d, si_l, si_r, 8'h00);
        m1 <= model_next(m1, rst, en, mode, d, si_l, si_r, 8'hA5);
        if (rst) valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            chk("model_q0", q0, m0);
            chk("model_q1", q1, m1);
            chk("model_msb0", {7'd0, msb0}, {7'd0, m0[7]});
            chk("model_lsb0", {7'd0, lsb0}, {7'd0, m0[0]});
            chk("model_msb1", {7'd0, msb1}, {7'd0, m1[7]});
            chk("model_lsb1", {7'd0, lsb1}, {7'd0, m1[0]});
        end
    end

    // Apply one set of inputs across one rising edge; returns at the negedge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] din, input logic sl, input logic sr);
        rst = r; en = e; mode = m; d = din; si_l = sl; si_r = sr;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] lsb_seq;
    logic [7:0] msb_seq;

    initial begin
        rst = 1'b0; en = 1'b0; mode = HOLD; d = 8'h00; si_l = 1'b0; si_r = 1'b0;
        lsb_seq = 8'b1000_0001;   // index i = edge i, ROR from 81
        msb_seq = 8'b0101_1010;   // index i = edge 7-i, SHL from 5A
        @(negedge clk);

        // Reset with arbitrary mode/en
        step(1'b1, 1'b1, SHL, 8'h3C, 1'b1, 1'b1);
        chk("reset_q0", q0, 8'h00);
        chk("reset_q1", q1, 8'hA5);

        // Load then hold with en=0
        step(1'b0, 1'b1, LOAD, 8'hB4, 1'b0, 1'b0);
        chk("load_b4", q0, 8'hB4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, LOAD, 8'hFF, 1'b1, 1'b1);
            chk("en0_hold", q0, 8'hB4);
        end

        // Shifts
        step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
        chk("shl_69", q0, 8'h69);
        step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 1'b0);
        chk("shr_34", q0, 8'h34);
        step(1'b0, 1'b1, LOAD, 8'h80, 1'b0, 1'b0);
        step(1'b0, 1'b1, ASR, 8'h00, 1'b0, 1'b1);
        chk("asr_c0", q0, 8'hC0);
        step(1'b0, 1'b1, ASR, 8'h00, 1'b0, 1'b0);
        chk("asr_e0", q0, 8'hE0);

        // Rotates and wrap-around
        step(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b0, 1'b1, ROL, 8'h00, 1'b0, 1'b0);
        chk("rol_03", q0, 8'h03);
        step(1'b0, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
        chk("ror_81", q0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            chk("ror_so_lsb", {7'd0, lsb0}, {7'd0, lsb_seq[i]});
            step(1'b0, 1'b1, ROR, 8'h00, 1'b1, 1'b1);
        end
        chk("ror8_81", q0, 8'h81);

        // SHL flushes all original bits
        step(1'b0, 1'b1, LOAD, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("shl_so_msb", {7'd0, msb0}, {7'd0, msb_seq[7-i]});
            step(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0);
        end
        chk("shl8_ff", q0, 8'hFF);

        // Mid-sequence reset, clear, hold
        step(1'b0, 1'b1, LOAD, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 1'b0);
        chk("shl3_d0", q0, 8'hD0);
        step(1'b1, 1'b1, LOAD, 8'hFF, 1'b1, 1'b1);
        chk("midrst_q0", q0, 8'h00);
        chk("midrst_q1", q1, 8'hA5);
        step(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b1, CLR, 8'hFF, 1'b1, 1'b1);
        chk("clr_q0", q0, 8'h00);
        chk("clr_q1", q1, 8'hA5);
        step(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b1, HOLD, 8'hFF, 1'b1, 1'b1);
        chk("hold_3c", q0, 8'h3C);
        step(1'b1, 1'b0, HOLD, 8'hFF, 1'b1, 1'b1);
        chk("rst_over_en0", q1, 8'hA5);

        // Randomized traffic checked by the model process
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
